// File: rtl/qea_host_pkg.sv
// qea_host_pkg: shared FSM states, fixed-point one and row-count helper for the QEA host sequencer
package qea_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CTX,
        INIT,
        START,
        RUN,
        READ
    } state_t;

    localparam int          NUM_FRAC_BIT_DEFAULT = 30;
    localparam logic [63:0] ONE                  = 64'd1 << NUM_FRAC_BIT_DEFAULT;

    // Fixed-point 1.0 for an arbitrary fraction width
    function automatic logic [63:0] one_fx(input int frac_bits);
        return 64'd1 << frac_bits;
    endfunction

    // STATE RAM rows holding 2^qbit amplitudes at 2^pe_num_width per row; 0 means too few qubits
    function automatic logic [63:0] row_count(input int qbit, input int pe_num_width);
        return (qbit > pe_num_width && qbit - pe_num_width < 64) ? 64'd1 << (qbit - pe_num_width) : 64'd0;
    endfunction

endpackage

// File: rtl/qea_readout_fifo.sv
// qea_readout_fifo: synchronous FIFO carrying a data row plus last-row flag, with full/empty/free status
module qea_readout_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_last,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_last,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH:0] r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic [AW:0]    w_count;
    logic           w_push;
    logic           w_pop;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = w_count == '0;
    assign o_full  = w_count == (AW+1)'(DEPTH);
    assign o_free  = (AW+1)'(DEPTH) - w_count;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Head entry is forced to zero when empty so the outputs read 0 out of reset
    assign {o_last, o_dout} = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Storage array, written on accepted push
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {i_last, i_din};
    end

    // Read/write pointers with one extra wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer: loads CTX RAM, initialises STATE RAM to |0..0>, starts QEA and streams out the final state.
// Optional QEA_CYCLE_COUNT_EN adds o_run_cycles, the START-to-complete cycle count.
module qea_host_sequencer
    import qea_host_pkg::*;
#(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int RD_LATENCY              = 1,
    parameter int OUT_FIFO_DEPTH          = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_launch,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_word,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_qea_start,
    input  logic                                 i_qea_complete,
    output logic                                 o_amp_valid,
    input  logic                                 i_amp_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_amp_data,
    output logic                                 o_amp_last,
    output logic                                 o_busy,
    output logic                                 o_err
`ifdef QEA_CYCLE_COUNT_EN
    ,
    output logic [31:0]                          o_run_cycles
`endif
);

    localparam int ROW_WIDTH  = PE_NUM*STATE_DATA_WIDTH;
    localparam int FREE_WIDTH = $clog2(OUT_FIFO_DEPTH) + 1;

    // |0..0> amplitude: real part 1.0 in the upper half of the top PE slot
    localparam logic [STATE_DATA_WIDTH-1:0] AMP_ONE = STATE_DATA_WIDTH'(DATA_WIDTH'(one_fx(NUM_FRAC_BIT))) << DATA_WIDTH;
    localparam logic [ROW_WIDTH-1:0]        ROW0    = ROW_WIDTH'(AMP_ONE) << (ROW_WIDTH - STATE_DATA_WIDTH);

    state_t                              r_state;
    state_t                              w_next;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  r_ctx_cnt;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  r_ctx_last;
    logic                                r_ctx_en;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  r_ctx_addr;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]  r_ctx_data;
    logic [STATE_ADDR_WIDTH-1:0]         r_row;
    logic [STATE_ADDR_WIDTH-1:0]         r_last_row;
    logic                                r_rd_all;
    logic [RD_LATENCY-1:0]               r_pipe_v;
    logic [RD_LATENCY-1:0]               r_pipe_last;
    logic                                r_err;
    logic [63:0]                         w_rows;
    logic                                w_fields_ok;
    logic                                w_accept;
    logic                                w_ctx_hs;
    logic                                w_issue;
    logic                                w_issue_last;
    logic                                w_pop;
    logic                                w_fifo_empty;
    logic                                w_fifo_full;
    logic [FREE_WIDTH-1:0]               w_free;
    logic [FREE_WIDTH-1:0]               w_inflight;

    assign w_rows       = row_count(int'(i_qbit_num), PE_NUM_WIDTH);
    assign w_fields_ok  = (w_rows != 64'd0) && (w_rows <= (64'd1 << STATE_ADDR_WIDTH)) && (i_ctx_num != '0);
    assign w_accept     = i_launch && r_state == IDLE;
    assign w_ctx_hs     = i_ctx_valid && o_ctx_ready;
    assign w_issue_last = r_row == r_last_row;
    assign w_issue      = r_state == READ && !r_rd_all && !w_fifo_full && (w_free > w_inflight);
    assign w_pop        = o_amp_valid && i_amp_ready;
    assign o_amp_valid  = !w_fifo_empty;
    assign o_ctx_en     = r_ctx_en;
    assign o_ctx_wea    = r_ctx_en;
    assign o_ctx_addr   = r_ctx_addr;
    assign o_ctx_data   = r_ctx_data;
    assign o_err        = r_err;

    // Reads issued but not yet landed in the FIFO; they already own a slot
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) w_inflight = w_inflight + FREE_WIDTH'(r_pipe_v[i]);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept && w_fields_ok) w_next = LOAD_CTX;
            LOAD_CTX: if (w_ctx_hs && r_ctx_cnt == r_ctx_last) w_next = INIT;
            INIT:     if (r_row == r_last_row) w_next = START;
            START:    w_next = RUN;
            RUN:      if (i_qea_complete) w_next = READ;
            READ:     if (w_pop && o_amp_last) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // FSM outputs: handshakes, RAM port controls and the start pulse
    always_comb begin
        o_ctx_ready   = r_state == LOAD_CTX;
        o_qea_start   = r_state == START;
        o_busy        = r_state != IDLE;
        o_state_wea   = r_state == INIT;
        o_state_ena   = (r_state == INIT) || w_issue;
        o_state_addra = o_state_ena ? r_row : '0;
        o_state_dina  = (r_state == INIT && r_row == '0) ? ROW0 : '0;
    end

    // Run fields, context write register, row counter and read-return pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctx_cnt   <= '0;
            r_ctx_last  <= '0;
            r_ctx_en    <= 1'b0;
            r_ctx_addr  <= '0;
            r_ctx_data  <= '0;
            r_row       <= '0;
            r_last_row  <= '0;
            r_rd_all    <= 1'b0;
            r_pipe_v    <= '0;
            r_pipe_last <= '0;
            r_err       <= 1'b0;
        end else begin
            r_ctx_en <= w_ctx_hs;
            if (w_ctx_hs) begin
                r_ctx_addr <= r_ctx_cnt;
                r_ctx_data <= i_ctx_word;
                r_ctx_cnt  <= r_ctx_cnt + GATE_CONTEXT_ADDR_WIDTH'(1);
            end
            if (w_accept) begin
                r_err      <= !w_fields_ok;
                r_ctx_cnt  <= '0;
                r_ctx_last <= i_ctx_num - GATE_CONTEXT_ADDR_WIDTH'(1);
                r_last_row <= STATE_ADDR_WIDTH'(w_rows - 64'd1);
                r_row      <= '0;
                r_rd_all   <= 1'b0;
            end
            if (r_state == INIT) r_row <= w_issue_last ? '0 : r_row + STATE_ADDR_WIDTH'(1);
            if (w_issue) begin
                r_row    <= r_row + STATE_ADDR_WIDTH'(1);
                r_rd_all <= w_issue_last;
            end
            r_pipe_v[0]    <= w_issue;
            r_pipe_last[0] <= w_issue && w_issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_v[i]    <= r_pipe_v[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
        end
    end

    qea_readout_fifo #(
        .WIDTH (ROW_WIDTH),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_pipe_v[RD_LATENCY-1]),
        .i_din   (i_state_dout),
        .i_last  (r_pipe_last[RD_LATENCY-1]),
        .i_pop   (i_amp_ready),
        .o_dout  (o_amp_data),
        .o_last  (o_amp_last),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_free  (w_free)
    );

`ifdef QEA_CYCLE_COUNT_EN
    logic [31:0] r_run_cycles;

    assign o_run_cycles = r_run_cycles;

    // Counts every RUN cycle, including the one that samples complete; saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  r_run_cycles <= '0;
        else if (w_accept)                           r_run_cycles <= '0;
        else if (r_state == RUN && r_run_cycles != '1) r_run_cycles <= r_run_cycles + 32'd1;
    end
`endif

endmodule
